lut_loader: RTL and testbench
=============================

Name: lut_loader

Overview:
- Programmable replacement for the fixed branch-target/address LUT: the writer side of the 4-bit index -> 10-bit offset table.
- Accepts a byte stream from the boot/test harness (valid/ready), assembles 16 x 10-bit entries into a shadow table and verifies an XOR checksum.
- Commits the shadow table atomically to the active table. The processor reads the active table combinationally (Index -> Out) exactly as it reads the fixed LUT.
- Sits beside the fetch unit; the processor's read port is never stalled by loading.

Parameters:
- ENTRIES, 16, number of table entries.
- IDX_W, 4, index width (log2 ENTRIES).
- DATA_W, 10, entry width, two's-complement offset.

Ports:
- Clk  input  1  single clock, rising edge.
- Reset_n  input  1  asynchronous active-low reset.
- Start  input  1  one-cycle request to begin a load; honoured only in IDLE or ERR.
- InByte  input  8  stream data byte.
- InValid  input  1  InByte valid.
- InReady  output  1  loader accepts InByte this cycle.
- Index  input  IDX_W  processor read index.
- Out  output  DATA_W  active-table entry at Index; combinational.
- Busy  output  1  high in LOAD_LO, LOAD_HI, CHECK and COMMIT.
- Done  output  1  one-cycle pulse when the commit takes effect.
- Err  output  1  level; last load rejected.

Behaviour:
- Reset (async, Reset_n=0): state IDLE; active and shadow tables all zero; entry counter 0; checksum 0; reserved-bit flag 0; InReady=0, Busy=0, Done=0, Err=0; Out=0 for every Index.
- Transfer: a byte moves on a rising edge with InValid && InReady. InReady=1 only in LOAD_LO, LOAD_HI and CHECK. InValid gaps are legal and cause no state change.
- Stream format, 33 bytes, in order:
  - For each entry k = 0..15: low byte = entry[7:0], then high byte with [1:0] = entry[9:8] and [7:2] reserved (must be 0).
  - Final byte = XOR of all 32 preceding bytes.
- FSM:
  - IDLE: Start -> LOAD_LO; clears counter, checksum, reserved flag and Err.
  - LOAD_LO: on transfer, latch low byte, XOR it into checksum -> LOAD_HI.
  - LOAD_HI: on transfer, write shadow[counter] = {InByte[1:0], low}; XOR into checksum; set reserved flag if InByte[7:2] != 0. If counter == ENTRIES-1 -> CHECK, else increment counter -> LOAD_LO.
  - CHECK: on transfer, if checksum == InByte and reserved flag == 0 -> COMMIT, else -> ERR.
  - COMMIT: one cycle; active <= shadow (all entries, same edge); Done=1 during this cycle; -> IDLE.
  - ERR: Err=1 (level); active table untouched. Start -> LOAD_LO (same clears as IDLE).
- Read port: Out = active[Index], pure combinational. During load, Out returns the pre-load contents. New contents are visible from the cycle after COMMIT.
- Counter never wraps: exactly 16 entries per load. Extra bytes after CHECK are not accepted (InReady=0).
- Start while Busy: ignored, no restart.
- Reset mid-load: everything cleared, including the active table (zero). Software must reload.
- Done and Err are never high together.

Decomposition:
- Package lut_loader_pkg: state enum (IDLE, LOAD_LO, LOAD_HI, CHECK, COMMIT, ERR); localparams STREAM_BYTES=33 and RSVD_MASK=8'hFC.
- One sub-module, lut_table: dual-bank storage (shadow write port, commit strobe, active combinational read port, async clear). The FSM and checksum stay in lut_loader.

Test Plan:
- Reset only -> Out=10'h000 for Index 0..15; InReady=0, Busy=0, Err=0.
- Start, then 33 bytes with all entries 0 except entry 5 = 10'h268 (-408) and correct checksum 8'h6A (0x68^0x02) -> Done pulses once exactly one cycle after the checksum transfer; Out(Index=5)=10'h268; other indices 0.
- Same stream but checksum 8'h00 -> Err=1, no Done; Out(5) keeps its prior value. A fresh Start with a correct stream clears Err and commits.
- Entry 3 high byte = 8'h06 (reserved bit 2 set), checksum otherwise correct -> Err=1; table unchanged.
- Random InValid gaps (valid 30% of cycles), plus a Start pulse mid-load -> result identical to the gapless load; the mid-load Start is ignored; Out(5) reads the old value until the commit edge.
- Reset_n asserted after 10 bytes of a load that follows a committed table -> immediately Out=0 for all indices, state IDLE; a subsequent full load succeeds.

Source files
------------

// File: rtl/lut_loader_pkg.sv
// Shared types and constants for the programmable offset-LUT loader.
package lut_loader_pkg;

  // Loader FSM states; encoding is exported on the debug state port.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD_LO = 3'd1,
    ST_LOAD_HI = 3'd2,
    ST_CHECK   = 3'd3,
    ST_COMMIT  = 3'd4,
    ST_ERR     = 3'd5
  } state_t;

  // A full load: two bytes per entry for 16 entries, then one checksum byte.
  localparam int STREAM_BYTES = 33;

  // High-byte bits that carry no entry data and must arrive as zero.
  localparam logic [7:0] RSVD_MASK = 8'hFC;

endpackage

// File: rtl/lut_table.sv
// Dual-bank LUT storage: a shadow bank filled one entry at a time and an
// active bank that copies the whole shadow bank on a single commit edge.
// The active bank is read combinationally and is never blocked by writes.
module lut_table #(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = 4,
  parameter int DATA_W  = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_wr_en,
  input  logic [IDX_W-1:0]  i_wr_idx,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_commit,
  input  logic [IDX_W-1:0]  i_rd_idx,
  output logic [DATA_W-1:0] o_rd_data
);

  logic [DATA_W-1:0] r_shadow [ENTRIES];
  logic [DATA_W-1:0] r_active [ENTRIES];

  // Shadow bank: one entry written per accepted high byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) r_shadow[i] <= '0;
    end else if (i_wr_en) begin
      r_shadow[i_wr_idx] <= i_wr_data;
    end
  end

  // Active bank: all entries replaced together so readers never see a mix.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) r_active[i] <= '0;
    end else if (i_commit) begin
      for (int i = 0; i < ENTRIES; i++) r_active[i] <= r_shadow[i];
    end
  end

  // Processor read port, same timing as the fixed LUT it replaces.
  always_comb begin
    o_rd_data = r_active[i_rd_idx];
  end

endmodule

// File: rtl/lut_loader.sv
// Byte-stream loader for the 16 x 10-bit offset LUT.
// Handshake: a byte is consumed on a rising edge where InValid && InReady;
// InValid may drop at any time without effect, and InReady depends only on
// the FSM state (high in LOAD_LO, LOAD_HI and CHECK), never on InValid.
// Stream: per entry low byte then high byte ({6'b0, entry[9:8]}), followed
// by the XOR of all 32 data bytes. Any reserved bit or a checksum mismatch
// rejects the load and leaves the active table as it was.
module lut_loader
  import lut_loader_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = 4,
  parameter int DATA_W  = 10
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              Start,
  input  logic [7:0]        InByte,
  input  logic              InValid,
  output logic              InReady,
  input  logic [IDX_W-1:0]  Index,
  output logic [DATA_W-1:0] Out,
  output logic              Busy,
  output logic              Done,
  output logic              Err,
  output logic [2:0]        o_dbg_state
);

  state_t            r_state;
  state_t            w_next;
  logic [IDX_W-1:0]  r_cnt;
  logic [7:0]        r_csum;
  logic [7:0]        r_lo;
  logic              r_rsvd;
  logic              w_ready;
  logic              w_xfer;
  logic              w_last;
  logic              w_start_ok;
  logic              w_wr_en;
  logic              w_commit;
  logic [DATA_W-1:0] w_wr_data;

  assign w_ready    = (r_state == ST_LOAD_LO) || (r_state == ST_LOAD_HI) ||
                      (r_state == ST_CHECK);
  assign w_xfer     = InValid && w_ready;
  assign w_last     = (r_cnt == IDX_W'(ENTRIES - 1));
  assign w_start_ok = Start && ((r_state == ST_IDLE) || (r_state == ST_ERR));
  assign w_wr_en    = w_xfer && (r_state == ST_LOAD_HI);
  assign w_wr_data  = {InByte[1:0], r_lo};
  assign w_commit   = (r_state == ST_COMMIT);

  // State register.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  // Next-state logic; Start is only looked at when not busy.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE, ST_ERR: if (w_start_ok) w_next = ST_LOAD_LO;
      ST_LOAD_LO:      if (w_xfer) w_next = ST_LOAD_HI;
      ST_LOAD_HI:      if (w_xfer) w_next = w_last ? ST_CHECK : ST_LOAD_LO;
      ST_CHECK: begin
        if (w_xfer) begin
          w_next = ((r_csum == InByte) && !r_rsvd) ? ST_COMMIT : ST_ERR;
        end
      end
      ST_COMMIT:       w_next = ST_IDLE;
      default:         w_next = ST_IDLE;
    endcase
  end

  // Outputs decoded from the current state only.
  always_comb begin
    InReady     = w_ready;
    Busy        = w_ready || (r_state == ST_COMMIT);
    Done        = (r_state == ST_COMMIT);
    Err         = (r_state == ST_ERR);
    o_dbg_state = r_state;
  end

  // Load bookkeeping: entry counter, running checksum, low-byte hold and
  // reserved-bit flag. The counter stops at the last entry, never wraps.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_cnt  <= '0;
      r_csum <= '0;
      r_lo   <= '0;
      r_rsvd <= 1'b0;
    end else if (w_start_ok) begin
      r_cnt  <= '0;
      r_csum <= '0;
      r_rsvd <= 1'b0;
    end else if (w_xfer && (r_state == ST_LOAD_LO)) begin
      r_lo   <= InByte;
      r_csum <= r_csum ^ InByte;
    end else if (w_wr_en) begin
      r_csum <= r_csum ^ InByte;
      if ((InByte & RSVD_MASK) != 8'h00) r_rsvd <= 1'b1;
      if (!w_last) r_cnt <= r_cnt + 1'b1;
    end
  end

  lut_table #(
    .ENTRIES (ENTRIES),
    .IDX_W   (IDX_W),
    .DATA_W  (DATA_W)
  ) u_table (
    .clk       (Clk),
    .rst_n     (Reset_n),
    .i_wr_en   (w_wr_en),
    .i_wr_idx  (r_cnt),
    .i_wr_data (w_wr_data),
    .i_commit  (w_commit),
    .i_rd_idx  (Index),
    .o_rd_data (Out)
  );

endmodule

// File: tb/tb_lut_loader.sv
// Bench for lut_loader: drives complete byte streams, keeps its own model of
// the active table, and queues the expected outcome of each load.
module tb_lut_loader;
  import lut_loader_pkg::*;

  localparam int ENTRIES = 16;
  localparam int IDX_W   = 4;
  localparam int DATA_W  = 10;

  logic              Clk;
  logic              Reset_n;
  logic              Start;
  logic [7:0]        InByte;
  logic              InValid;
  logic              InReady;
  logic [IDX_W-1:0]  Index;
  logic [DATA_W-1:0] Out;
  logic              Busy;
  logic              Done;
  logic              Err;
  logic [2:0]        o_dbg_state;

  int total;
  int bad;

  // Expected outcome per load: 2'b01 = Done, 2'b10 = Err ({Err, Done}).
  logic [1:0]        exp_q[$];
  logic [DATA_W-1:0] model_tab [ENTRIES];
  logic [DATA_W-1:0] stim_tab  [ENTRIES];

  lut_loader #(
    .ENTRIES (ENTRIES),
    .IDX_W   (IDX_W),
    .DATA_W  (DATA_W)
  ) dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .Start       (Start),
    .InByte      (InByte),
    .InValid     (InValid),
    .InReady     (InReady),
    .Index       (Index),
    .Out         (Out),
    .Busy        (Busy),
    .Done        (Done),
    .Err         (Err),
    .o_dbg_state (o_dbg_state)
  );

  // Clock and reset defaults.
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // ---------------- driver tasks ----------------

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic pulse_start();
    Start = 1'b1;
    tick();
    Start = 1'b0;
  endtask

  // Offer one byte; with gaps, InValid is high on ~30% of cycles.
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int guard;
    if (gaps) begin
      while ($urandom_range(0, 99) >= 30) begin
        InValid = 1'b0;
        tick();
      end
    end
    InByte  = b;
    InValid = 1'b1;
    guard   = 0;
    while (!InReady && guard < 50) begin
      tick();
      guard++;
    end
    total++;
    if (!InReady) begin
      bad++;
      $display("FAIL inready_timeout: InReady=%b required=1", InReady);
    end
    tick();
    InValid = 1'b0;
  endtask

  // Compare every Index against the model table.
  task automatic check_table(input string name);
    for (int i = 0; i < ENTRIES; i++) begin
      Index = IDX_W'(i);
      #1;
      total++;
      if (Out !== model_tab[i]) begin
        bad++;
        $display("FAIL %s idx=%0d: Out=%h required=%h", name, i, Out, model_tab[i]);
      end
    end
  endtask

  task automatic clear_stim();
    for (int i = 0; i < ENTRIES; i++) stim_tab[i] = '0;
  endtask

  task automatic random_stim();
    for (int i = 0; i < ENTRIES; i++) stim_tab[i] = DATA_W'($urandom_range(0, 1023));
  endtask

  // Full load of stim_tab. bad_csum corrupts the final byte, rsvd_idx >= 0
  // sets reserved bit 2 in that entry's high byte (checksum kept consistent),
  // start_at >= 0 pulses Start before that byte.
  task automatic run_load(input string name, input bit bad_csum, input int rsvd_idx,
                          input bit gaps, input int start_at);
    logic [7:0] s [STREAM_BYTES];
    logic [7:0] cs;
    logic [1:0] exp_code;
    logic [1:0] got;
    bit         commit;
    cs = 8'h00;
    for (int k = 0; k < ENTRIES; k++) begin
      s[2*k]   = stim_tab[k][7:0];
      s[2*k+1] = {6'b0, stim_tab[k][9:8]};
      if (k == rsvd_idx) s[2*k+1][2] = 1'b1;
    end
    for (int i = 0; i < STREAM_BYTES - 1; i++) cs = cs ^ s[i];
    s[STREAM_BYTES-1] = bad_csum ? ~cs : cs;
    commit = !bad_csum && (rsvd_idx < 0);
    exp_q.push_back(commit ? 2'b01 : 2'b10);

    Index = IDX_W'(5);
    pulse_start();
    total++;
    if (Busy !== 1'b1 || Err !== 1'b0) begin
      bad++;
      $display("FAIL %s_started: Busy=%b Err=%b required Busy=1 Err=0", name, Busy, Err);
    end

    for (int i = 0; i < STREAM_BYTES; i++) begin
      if (i == start_at) begin
        pulse_start();
        total++;
        if (o_dbg_state !== ((i % 2 == 1) ? ST_LOAD_HI : ST_LOAD_LO)) begin
          bad++;
          $display("FAIL %s_mid_start: state=%0d required=%0d", name, o_dbg_state,
                   (i % 2 == 1) ? ST_LOAD_HI : ST_LOAD_LO);
        end
      end
      send_byte(s[i], gaps);
    end

    // One cycle after the checksum transfer: outcome visible, table still old.
    got      = {Err, Done};
    exp_code = exp_q.pop_front();
    total++;
    if (got !== exp_code) begin
      bad++;
      $display("FAIL %s_outcome: {Err,Done}=%b required=%b", name, got, exp_code);
    end
    total++;
    if (Out !== model_tab[5]) begin
      bad++;
      $display("FAIL %s_old_out5: Out=%h required=%h", name, Out, model_tab[5]);
    end

    tick();
    total++;
    if (Done !== 1'b0 || Err !== !commit) begin
      bad++;
      $display("FAIL %s_after: Done=%b Err=%b required Done=0 Err=%b", name, Done, Err, !commit);
    end
    if (commit) begin
      for (int i = 0; i < ENTRIES; i++) model_tab[i] = stim_tab[i];
    end
    check_table({name, "_table"});
  endtask

  // ---------------- scenario tasks ----------------

  task automatic test_reset();
    Reset_n = 1'b0;
    Start   = 1'b0;
    InByte  = 8'h00;
    InValid = 1'b0;
    Index   = '0;
    for (int i = 0; i < ENTRIES; i++) model_tab[i] = '0;
    repeat (3) tick();
    Reset_n = 1'b1;
    tick();
    total++;
    if (InReady !== 1'b0 || Busy !== 1'b0 || Err !== 1'b0 || Done !== 1'b0) begin
      bad++;
      $display("FAIL reset_flags: InReady=%b Busy=%b Err=%b Done=%b required all 0",
               InReady, Busy, Err, Done);
    end
    total++;
    if (o_dbg_state !== ST_IDLE) begin
      bad++;
      $display("FAIL reset_state: state=%0d required=%0d", o_dbg_state, ST_IDLE);
    end
    check_table("reset_table");
  endtask

  task automatic test_commit();
    clear_stim();
    stim_tab[5] = 10'h268;
    run_load("commit", 1'b0, -1, 1'b0, -1);
  endtask

  task automatic test_bad_csum();
    clear_stim();
    stim_tab[5] = 10'h111;
    run_load("bad_csum", 1'b1, -1, 1'b0, -1);
    clear_stim();
    stim_tab[0] = 10'h155;
    stim_tab[5] = 10'h2AA;
    run_load("recover", 1'b0, -1, 1'b0, -1);
  endtask

  task automatic test_reserved();
    clear_stim();
    stim_tab[3] = 10'h200;
    run_load("reserved", 1'b0, 3, 1'b0, -1);
  endtask

  task automatic test_gaps();
    logic [DATA_W-1:0] keep [ENTRIES];
    random_stim();
    for (int i = 0; i < ENTRIES; i++) keep[i] = stim_tab[i];
    run_load("gapless", 1'b0, -1, 1'b0, -1);
    random_stim();
    run_load("other", 1'b0, -1, 1'b0, -1);
    for (int i = 0; i < ENTRIES; i++) stim_tab[i] = keep[i];
    run_load("gaps", 1'b0, -1, 1'b1, 11);
  endtask

  task automatic test_reset_mid();
    random_stim();
    run_load("pre_reset", 1'b0, -1, 1'b0, -1);
    random_stim();
    pulse_start();
    for (int i = 0; i < 10; i++) send_byte(8'(i * 37 + 1), 1'b0);
    Reset_n = 1'b0;
    #1;
    for (int i = 0; i < ENTRIES; i++) model_tab[i] = '0;
    total++;
    if (o_dbg_state !== ST_IDLE || Busy !== 1'b0 || InReady !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset_state: state=%0d Busy=%b InReady=%b required 0/0/0",
               o_dbg_state, Busy, InReady);
    end
    check_table("mid_reset_table");
    @(negedge Clk);
    Reset_n = 1'b1;
    tick();
    run_load("post_reset", 1'b0, -1, 1'b0, -1);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_commit();
    test_bad_csum();
    test_reserved();
    test_gaps();
    test_reset_mid();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL leftover_expect: size=%0d required=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
